mem_port_arbiter: RTL and testbench

Shares the single physical-memory port between the instruction-cache and data-cache miss paths of the pipelined datapath.
- One transaction at a time; requester handshake is the existing read/write/resp style.
- Fixed data-side priority, with an anti-starvation override after consecutive data grants.
- Watchdog flags a downstream transaction that never completes.

---
 rtl/mem_port_arbiter_pkg.sv | 35 +++
 rtl/mem_port_arbiter_watchdog.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the I/D cache miss-path arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

  localparam int unsigned STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_SAT = 4'd15;
  localparam int unsigned WD_W = 10;

  function automatic arb_owner_t owner_of(input arb_state_t s);
    arb_owner_t o;
    case (s)
      GRANT_I: o = OWN_I;
      GRANT_D: o = OWN_D;
      default: o = OWN_NONE;
    endcase
    return o;
  endfunction

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (v == STARVE_SAT) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Grant-phase watchdog: counts grant cycles without a downstream response
// and raises a sticky error when the limit is reached.
module mem_port_arbiter_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_run,
  input  logic i_done,
  output logic o_expire,
  output logic o_err
);

  localparam logic [WD_W-1:0] LP_LIMIT = WD_W'(TIMEOUT);

  logic [WD_W-1:0] r_cnt;
  logic [WD_W-1:0] w_cnt_next;
  logic            r_err;

  // Expiry fires on the grant cycle whose increment would reach the limit.
  assign w_cnt_next = r_cnt + 10'd1;
  assign o_expire   = i_run && !i_done && (w_cnt_next == LP_LIMIT);
  assign o_err      = r_err;

  // Counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 10'd0;
      r_err <= 1'b0;
    end else begin
      if (i_start) begin
        r_cnt <= 10'd0;
      end else if (i_run && !i_done) begin
        r_cnt <= w_cnt_next;
      end else begin
        r_cnt <= r_cnt;
      end
      if (o_expire) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one physical-memory port between I-cache and D-cache miss paths:
// data-side priority with an anti-starvation override and a grant watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = 256,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              busy,
  output logic              err_timeout
);

  arb_state_t          r_state;
  arb_owner_t          w_owner;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic                r_pmem_read;
  logic                r_pmem_write;
  logic [ADDR_W-1:0]   r_pmem_address;
  logic [LINE_W-1:0]   r_pmem_wdata;
  logic [LINE_W-1:0]   r_i_rdata;
  logic [LINE_W-1:0]   r_d_rdata;
  logic                w_d_req;
  logic                w_i_req;
  logic                w_pick_i;
  logic                w_pick_d;
  logic                w_start;
  logic                w_run;
  logic                w_expire;
  logic                w_err;
  logic                w_i_done;
  logic                w_d_done;

  assign w_owner  = owner_of(r_state);
  assign w_d_req  = d_read | d_write;
  assign w_i_req  = i_read;
  // I wins only when D is idle or has used up its consecutive-grant allowance.
  assign w_pick_i = (r_state == IDLE) && w_i_req &&
                    (!w_d_req || (r_starve_cnt >= STARVE_W'(STARVE_MAX)));
  assign w_pick_d = (r_state == IDLE) && w_d_req && !w_pick_i;
  assign w_start  = w_pick_i | w_pick_d;
  assign w_run    = (w_owner != OWN_NONE);
  assign w_i_done = (w_owner == OWN_I) && pmem_resp;
  assign w_d_done = (w_owner == OWN_D) && pmem_resp;

  assign i_resp       = w_i_done;
  assign d_resp       = w_d_done;
  assign i_rdata      = w_i_done ? pmem_rdata : r_i_rdata;
  assign d_rdata      = w_d_done ? pmem_rdata : r_d_rdata;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
  assign busy         = (r_state != IDLE);
  assign err_timeout  = w_err;

  mem_port_arbiter_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_run    (w_run),
    .i_done   (pmem_resp),
    .o_expire (w_expire),
    .o_err    (w_err)
  );

  // Arbitration FSM with grant-time latches and the starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_starve_cnt   <= 4'd0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_i_rdata      <= '0;
      r_d_rdata      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state        <= GRANT_D;
            r_pmem_address <= d_address;
            r_pmem_wdata   <= d_wdata;
            r_pmem_write   <= d_write;
            r_pmem_read    <= ~d_write;
            r_starve_cnt   <= w_i_req ? sat_inc(r_starve_cnt) : 4'd0;
          end else if (w_pick_i) begin
            r_state        <= GRANT_I;
            r_pmem_address <= i_address;
            r_pmem_wdata   <= d_wdata;
            r_pmem_write   <= 1'b0;
            r_pmem_read    <= 1'b1;
            r_starve_cnt   <= 4'd0;
          end else begin
            r_state <= IDLE;
          end
        end
        GRANT_I, GRANT_D: begin
          if (pmem_resp) begin
            if (r_state == GRANT_I) begin
              r_i_rdata <= pmem_rdata;
            end else begin
              r_d_rdata <= pmem_rdata;
            end
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_state      <= RECOVER;
          end else if (w_expire) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_state      <= RECOVER;
          end else begin
            r_state <= r_state;
          end
        end
        RECOVER: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected transactions are queued at
// request time and checked against what appears on the pmem and resp ports.
module tb_mem_port_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         busy;
  logic         err_timeout;

  typedef struct {
    logic         is_d;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
  } exp_t;

  exp_t         exp_q[$];
  int           n_pass = 0;
  int           n_total = 0;
  logic [255:0] last_i_rdata = '0;

  mem_port_arbiter #(
    .ADDR_W(32), .LINE_W(256), .STARVE_MAX(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Downstream memory model: wait for a strobe, respond after lat cycles,
  // and report what the DUT presented. Returns at the RECOVER-cycle negedge.
  task automatic serve(input int lat, input logic [255:0] val,
                       input bit drop_i, input bit drop_d,
                       output int wait_n, output logic o_rd, output logic o_wr,
                       output logic [31:0] o_addr, output logic [255:0] o_wd,
                       output logic o_iresp, output logic o_dresp,
                       output logic [255:0] o_irdata, output logic [255:0] o_drdata);
    wait_n = 0;
    o_rd = 1'b0; o_wr = 1'b0; o_addr = '0; o_wd = '0;
    o_iresp = 1'b0; o_dresp = 1'b0; o_irdata = '0; o_drdata = '0;
    while (!(pmem_read || pmem_write) && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (pmem_read || pmem_write) begin
      o_rd = pmem_read; o_wr = pmem_write; o_addr = pmem_address; o_wd = pmem_wdata;
      for (int k = 1; k < lat; k++) @(negedge clk);
      pmem_rdata = val;
      pmem_resp  = 1'b1;
      #1;
      o_iresp = i_resp; o_dresp = d_resp; o_irdata = i_rdata; o_drdata = d_rdata;
      if (drop_i && o_iresp) i_read = 1'b0;
      if (drop_d && o_dresp) begin d_read = 1'b0; d_write = 1'b0; end
      @(negedge clk);
      pmem_resp = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    n_total++; if ({pmem_read, pmem_write, i_resp, d_resp, busy, err_timeout} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {pmem_read, pmem_write, i_resp, d_resp, busy, err_timeout}); else n_pass++;
    n_total++; if (pmem_address !== 32'h0) $display("FAIL reset_addr: got %h want 0", pmem_address); else n_pass++;
    n_total++; if ((pmem_wdata | i_rdata | d_rdata) !== 256'h0)
      $display("FAIL reset_data: got nonzero line outputs"); else n_pass++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i_read();
    exp_t e; int w; logic rd, wr, ir, dr; logic [31:0] a; logic [255:0] wd, irv, drv;
    e = '{1'b0, 1'b0, 32'h0000_0040, 256'h0, {32{8'hA5}}};
    exp_q.push_back(e);
    i_read = 1'b1; i_address = 32'h0000_0040;
    serve(5, {32{8'hA5}}, 1'b1, 1'b0, w, rd, wr, a, wd, ir, dr, irv, drv);
    e = exp_q.pop_front();
    n_total++; if (w !== 1) $display("FAIL i_read_latency: got %0d want 1", w); else n_pass++;
    n_total++; if ({rd, wr} !== 2'b10) $display("FAIL i_read_op: got %b want 10", {rd, wr}); else n_pass++;
    n_total++; if (a !== e.addr) $display("FAIL i_read_addr: got %h want %h", a, e.addr); else n_pass++;
    n_total++; if ({ir, dr} !== 2'b10) $display("FAIL i_read_resp: got %b want 10", {ir, dr}); else n_pass++;
    n_total++; if (irv !== e.rdata) $display("FAIL i_read_rdata: got %h want %h", irv, e.rdata); else n_pass++;
    last_i_rdata = e.rdata;
    n_total++; if ({i_resp, pmem_read, busy} !== 3'b001)
      $display("FAIL i_read_recover: got %b want 001", {i_resp, pmem_read, busy}); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL i_read_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_d_write();
    exp_t e; int w; logic rd, wr, ir, dr; logic [31:0] a; logic [255:0] wd, irv, drv;
    e = '{1'b1, 1'b1, 32'h0000_0100, 256'h1234, 256'h0};
    exp_q.push_back(e);
    d_write = 1'b1; d_address = 32'h0000_0100; d_wdata = 256'h1234;
    serve(3, rnd_line(), 1'b0, 1'b1, w, rd, wr, a, wd, ir, dr, irv, drv);
    e = exp_q.pop_front();
    n_total++; if ({rd, wr} !== 2'b01) $display("FAIL d_write_op: got %b want 01", {rd, wr}); else n_pass++;
    n_total++; if (a !== e.addr) $display("FAIL d_write_addr: got %h want %h", a, e.addr); else n_pass++;
    n_total++; if (wd !== e.wdata) $display("FAIL d_write_wdata: got %h want %h", wd, e.wdata); else n_pass++;
    n_total++; if ({ir, dr} !== 2'b01) $display("FAIL d_write_resp: got %b want 01", {ir, dr}); else n_pass++;
    n_total++; if (d_resp !== 1'b0) $display("FAIL d_write_pulse: got %b want 0", d_resp); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_simultaneous(input int tag);
    exp_t e; int w; logic rd, wr, ir, dr; logic [31:0] a; logic [255:0] wd, irv, drv;
    exp_q.push_back('{1'b1, 1'b0, 32'h0000_0200 + 32'(tag), 256'h0, rnd_line()});
    exp_q.push_back('{1'b0, 1'b0, 32'h0000_0080 + 32'(tag), 256'h0, rnd_line()});
    d_read = 1'b1; d_address = 32'h0000_0200 + 32'(tag);
    i_read = 1'b1; i_address = 32'h0000_0080 + 32'(tag);
    for (int t = 0; t < 2; t++) begin
      e = exp_q.pop_front();
      serve(2 + t, e.rdata, 1'b1, 1'b1, w, rd, wr, a, wd, ir, dr, irv, drv);
      n_total++; if ({dr, ir} !== {e.is_d, ~e.is_d})
        $display("FAIL simul_order%0d_%0d: got d/i %b want %b", tag, t, {dr, ir}, {e.is_d, ~e.is_d}); else n_pass++;
      n_total++; if (a !== e.addr) $display("FAIL simul_addr%0d_%0d: got %h want %h", tag, t, a, e.addr); else n_pass++;
      if (e.is_d) begin
        n_total++; if (drv !== e.rdata) $display("FAIL simul_drdata%0d: got %h want %h", tag, drv, e.rdata); else n_pass++;
        n_total++; if (irv !== last_i_rdata) $display("FAIL simul_ihold%0d: got %h want %h", tag, irv, last_i_rdata); else n_pass++;
      end else begin
        n_total++; if (irv !== e.rdata) $display("FAIL simul_irdata%0d: got %h want %h", tag, irv, e.rdata); else n_pass++;
        last_i_rdata = e.rdata;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    exp_t e; int w; logic rd, wr, ir, dr; logic [31:0] a; logic [255:0] wd, irv, drv;
    for (int t = 0; t < 4; t++) exp_q.push_back('{1'b1, 1'b1, 32'h0000_0300, 256'h0, 256'h0});
    exp_q.push_back('{1'b0, 1'b0, 32'h0000_0400, 256'h0, rnd_line()});
    d_write = 1'b1; d_address = 32'h0000_0300; d_wdata = rnd_line();
    i_read = 1'b1; i_address = 32'h0000_0400;
    for (int t = 0; t < 5; t++) begin
      e = exp_q.pop_front();
      serve(2, e.rdata, 1'b1, 1'b0, w, rd, wr, a, wd, ir, dr, irv, drv);
      n_total++; if ({dr, ir} !== {e.is_d, ~e.is_d})
        $display("FAIL starve_order%0d: got d/i %b want %b", t, {dr, ir}, {e.is_d, ~e.is_d}); else n_pass++;
      n_total++; if ({a, wr} !== {e.addr, e.wr})
        $display("FAIL starve_txn%0d: got %h/%b want %h/%b", t, a, wr, e.addr, e.wr); else n_pass++;
      if (!e.is_d) begin
        n_total++; if (irv !== e.rdata) $display("FAIL starve_irdata: got %h want %h", irv, e.rdata); else n_pass++;
        last_i_rdata = e.rdata;
      end
    end
    d_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    exp_t e; int w, n; logic rd, wr, ir, dr, dseen; logic [31:0] a; logic [255:0] wd, irv, drv;
    exp_q.push_back('{1'b1, 1'b0, 32'h0000_0500, 256'h0, rnd_line()});
    d_read = 1'b1; d_address = 32'h0000_0500;
    w = 0;
    while (!pmem_read && w < 20) begin @(negedge clk); w++; end
    n = 1; dseen = 1'b0;
    while (pmem_read && n < 40) begin
      @(negedge clk);
      if (d_resp) dseen = 1'b1;
      if (pmem_read) n++;
    end
    n_total++; if (n !== 8) $display("FAIL timeout_cycles: got %0d want 8", n); else n_pass++;
    n_total++; if ({err_timeout, busy, dseen} !== 3'b110)
      $display("FAIL timeout_state: got %b want 110", {err_timeout, busy, dseen}); else n_pass++;
    e = exp_q.pop_front();
    serve(2, e.rdata, 1'b0, 1'b1, w, rd, wr, a, wd, ir, dr, irv, drv);
    n_total++; if ({dr, rd, a} !== {1'b1, 1'b1, e.addr})
      $display("FAIL timeout_regrant: got %b/%b/%h want 1/1/%h", dr, rd, a, e.addr); else n_pass++;
    n_total++; if (drv !== e.rdata) $display("FAIL timeout_rdata: got %h want %h", drv, e.rdata); else n_pass++;
    n_total++; if (err_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", err_timeout); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int w; logic seen_i;
    i_read = 1'b1; i_address = 32'h0000_0600;
    w = 0;
    while (!pmem_read && w < 20) begin @(negedge clk); w++; end
    n_total++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_0600})
      $display("FAIL rstmid_grant: got %b/%h want 1/00000600", pmem_read, pmem_address); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++; if ({pmem_read, busy, err_timeout} !== 3'b000)
      $display("FAIL rstmid_ctrl: got %b want 000", {pmem_read, busy, err_timeout}); else n_pass++;
    n_total++; if ((pmem_address !== 32'h0) || ((i_rdata | d_rdata) !== 256'h0))
      $display("FAIL rstmid_data: got addr %h want 0 and zero rdata", pmem_address); else n_pass++;
    i_read = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    pmem_rdata = rnd_line(); pmem_resp = 1'b1;
    #1 seen_i = i_resp;
    @(negedge clk); pmem_resp = 1'b0;
    n_total++; if ({seen_i, i_resp, busy} !== 3'b000)
      $display("FAIL rstmid_late_resp: got %b want 000", {seen_i, i_resp, busy}); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b0; i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    test_reset();
    test_i_read();
    test_d_write();
    test_simultaneous(0);
    test_starvation();
    test_simultaneous(4);
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
